// File: rtl/alu_sequencer_if.sv
// Bundle of the sequencer's handshake, register-load and ALU-side signals.
// The master side issues commands, loads registers, consumes responses and
// hosts the combinational ALU; the slave side is the sequencer itself.
interface alu_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
);
  localparam int AW = $clog2(NREG);

  logic              ld_en;
  logic [AW-1:0]     ld_addr;
  logic [DATA_W-1:0] ld_data;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [AW-1:0]     cmd_ra;
  logic [AW-1:0]     cmd_rb;
  logic [AW-1:0]     cmd_rd;
  logic [2:0]        cmd_count;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_control;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  logic [AW-1:0]     rsp_rd;

  modport master (
    output ld_en, ld_addr, ld_data,
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_count,
    input  cmd_ready,
    input  alu_a, alu_b, alu_control,
    output alu_result, alu_zero,
    input  rsp_valid, rsp_data, rsp_zero, rsp_rd,
    output rsp_ready
  );

  modport slave (
    input  ld_en, ld_addr, ld_data,
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_count,
    output cmd_ready,
    output alu_a, alu_b, alu_control,
    input  alu_result, alu_zero,
    output rsp_valid, rsp_data, rsp_zero, rsp_rd,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Command front-end for the 8-bit combinational ALU. Accepts a command,
// runs the ALU cmd_count+1 times feeding the result back as operand A,
// writes the final result to the register file and returns it.
module alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input logic            clk,
  input logic            rst,
  alu_sequencer_if.slave bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] bval_q;
  logic [2:0]        op_q;
  logic [2:0]        iter_q;
  logic [AW-1:0]     rd_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_zero_q;
  logic [AW-1:0]     rsp_rd_q;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];

  logic              last_pass;

  assign last_pass = (state_q == EXEC) && (iter_q == 3'd0);

  // ALU is only driven while a pass is actually running; quiet otherwise.
  assign bus.alu_a       = (state_q == EXEC) ? acc_q  : '0;
  assign bus.alu_b       = (state_q == EXEC) ? bval_q : '0;
  assign bus.alu_control = (state_q == EXEC) ? op_q   : 3'd0;

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_rd    = rsp_rd_q;

  // Register-file next state: external load first, writeback last so it wins a same-address collision.
  always_comb begin
    rf_d = rf_q;
    if (bus.ld_en) begin
      rf_d[bus.ld_addr] = bus.ld_data;
    end
    if (last_pass) begin
      rf_d[rd_q] = bus.alu_result;
    end
  end

  // Register file storage; cleared by reset so an abandoned command leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  // Command FSM: latch operands at accept (old register values), iterate, then hold the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      bval_q     <= '0;
      op_q       <= 3'd0;
      iter_q     <= 3'd0;
      rd_q       <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_rd_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q    <= bus.cmd_op;
            rd_q    <= bus.cmd_rd;
            iter_q  <= bus.cmd_count;
            acc_q   <= rf_q[bus.cmd_ra];
            bval_q  <= rf_q[bus.cmd_rb];
            state_q <= EXEC;
          end
        end
        EXEC: begin
          acc_q <= bus.alu_result;
          if (iter_q == 3'd0) begin
            rsp_data_q <= bus.alu_result;
            rsp_zero_q <= bus.alu_zero;
            rsp_rd_q   <= rd_q;
            state_q    <= RESP;
          end else begin
            iter_q <= iter_q - 3'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: models the combinational ALU, drives a table
// of single/multi-pass commands, then hand-written corner-case sequences.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  alu_sequencer_if #(.DATA_W(8), .NREG(4)) bus ();

  alu_sequencer #(.DATA_W(8), .NREG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 pass A, 110 A<<1, 111 A>>1
  function automatic logic [7:0] alu_f(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return a;
      3'b110:  return {a[6:0], 1'b0};
      default: return {1'b0, a[7:1]};
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_control, bus.alu_a, bus.alu_b);
  assign bus.alu_zero   = (bus.alu_result == 8'h00);

  typedef struct {
    logic       pre;
    logic [1:0] pa;
    logic [7:0] pd;
    logic [2:0] op;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [1:0] rd;
    logic [2:0] cnt;
    logic [7:0] exp;
    logic       ez;
  } vec_t;

  vec_t       tbl [15];
  logic [7:0] tr_a [16];
  logic [2:0] tr_c [16];
  int         tr_n;
  logic [7:0] r_data;
  logic       r_zero;
  logic [1:0] r_rd;
  int         r_lat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    tick();
    bus.ld_en   = 1'b0;
  endtask

  // Issue one command, record the ALU operand trace, wait for and consume the response.
  // r_lat counts cycles from the handshake cycle to the first rsp_valid cycle.
  task automatic run_cmd(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                         input logic [1:0] rd, input logic [2:0] cnt);
    int w;
    w = 0;
    while (!bus.cmd_ready && w < 20) begin
      tick();
      w++;
    end
    if (!bus.cmd_ready) begin
      nchk++;
      nerr++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1");
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_ra    = ra;
    bus.cmd_rb    = rb;
    bus.cmd_rd    = rd;
    bus.cmd_count = cnt;
    tick();
    bus.cmd_valid = 1'b0;
    r_lat = 1;
    tr_n  = 0;
    while (!bus.rsp_valid && r_lat < 20) begin
      if (tr_n < 16) begin
        tr_a[tr_n] = bus.alu_a;
        tr_c[tr_n] = bus.alu_control;
        tr_n++;
      end
      tick();
      r_lat++;
    end
    if (!bus.rsp_valid) begin
      nchk++;
      nerr++;
      $display("FAIL rsp_valid_timeout: got 0 expected 1");
    end
    r_data = bus.rsp_data;
    r_zero = bus.rsp_zero;
    r_rd   = bus.rsp_rd;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  // Read a register back through a pass-A command that rewrites it with its own value.
  task automatic read_reg(input logic [1:0] r, input logic [7:0] exp, input string name);
    run_cmd(3'b101, r, 2'd0, r, 3'd0);
    check(name, r_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;

    //                 pre   pa    pd     op      ra    rb    rd    cnt   exp    ez
    tbl[0]  = '{1'b0, 2'd0, 8'h00, 3'b000, 2'd0, 2'd1, 2'd2, 3'd0, 8'h10, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 8'h00, 3'b101, 2'd2, 2'd0, 2'd2, 3'd0, 8'h10, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 8'h00, 3'b001, 2'd0, 2'd1, 2'd3, 3'd0, 8'h0E, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 8'h00, 3'b010, 2'd0, 2'd3, 2'd2, 3'd0, 8'h0E, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 8'h00, 3'b011, 2'd1, 2'd3, 2'd2, 3'd0, 8'h0F, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 8'h00, 3'b100, 2'd0, 2'd2, 2'd2, 3'd0, 8'h00, 1'b1};
    tbl[6]  = '{1'b0, 2'd0, 8'h00, 3'b110, 2'd0, 2'd0, 2'd3, 3'd0, 8'h1E, 1'b0};
    tbl[7]  = '{1'b1, 2'd0, 8'hFF, 3'b000, 2'd0, 2'd1, 2'd0, 3'd0, 8'h00, 1'b1};
    tbl[8]  = '{1'b1, 2'd1, 8'h05, 3'b101, 2'd1, 2'd1, 2'd1, 3'd0, 8'h05, 1'b0};
    tbl[9]  = '{1'b1, 2'd0, 8'h05, 3'b001, 2'd0, 2'd1, 2'd2, 3'd0, 8'h00, 1'b1};
    tbl[10] = '{1'b1, 2'd1, 8'h01, 3'b000, 2'd1, 2'd1, 2'd1, 3'd2, 8'h04, 1'b0};
    tbl[11] = '{1'b0, 2'd0, 8'h00, 3'b101, 2'd1, 2'd0, 2'd0, 3'd0, 8'h04, 1'b0};
    tbl[12] = '{1'b1, 2'd2, 8'h33, 3'b100, 2'd2, 2'd2, 2'd3, 3'd1, 8'h33, 1'b0};
    tbl[13] = '{1'b0, 2'd0, 8'h00, 3'b100, 2'd2, 2'd2, 2'd3, 3'd2, 8'h00, 1'b1};
    tbl[14] = '{1'b1, 2'd0, 8'h10, 3'b000, 2'd0, 2'd1, 2'd0, 3'd7, 8'h30, 1'b0};

    rst           = 1'b1;
    bus.ld_en     = 1'b0;
    bus.ld_addr   = 2'd0;
    bus.ld_data   = 8'h00;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_ra    = 2'd0;
    bus.cmd_rb    = 2'd0;
    bus.cmd_rd    = 2'd0;
    bus.cmd_count = 3'd0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_zero", bus.rsp_zero, 0);
    check("rst_rsp_rd", bus.rsp_rd, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_control", bus.alu_control, 0);
    rst = 1'b0;
    tick();
    for (int r = 0; r < 4; r++) read_reg(r[1:0], 8'h00, $sformatf("rst_r%0d", r));

    load(2'd0, 8'h0F);
    load(2'd1, 8'h01);
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].pre) load(tbl[i].pa, tbl[i].pd);
      run_cmd(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].rd, tbl[i].cnt);
      check($sformatf("v%0d_data", i), r_data, tbl[i].exp);
      check($sformatf("v%0d_zero", i), r_zero, tbl[i].ez);
      check($sformatf("v%0d_rd", i), r_rd, tbl[i].rd);
      check($sformatf("v%0d_latency", i), r_lat, tbl[i].cnt + 2);
    end

    // Iterated shift-right: operand A must follow the fed-back result.
    load(2'd3, 8'h80);
    run_cmd(3'b111, 2'd3, 2'd0, 2'd3, 3'd3);
    check("iter_trace_n", tr_n, 4);
    check("iter_a0", tr_a[0], 8'h80);
    check("iter_a1", tr_a[1], 8'h40);
    check("iter_a2", tr_a[2], 8'h20);
    check("iter_a3", tr_a[3], 8'h10);
    check("iter_ctl", tr_c[0], 3'b111);
    check("iter_data", r_data, 8'h08);
    check("iter_latency", r_lat, 5);
    read_reg(2'd3, 8'h08, "iter_r3");

    // Backpressure: response held while new commands are offered.
    load(2'd0, 8'h0F);
    load(2'd1, 8'h01);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'b000; bus.cmd_ra = 2'd0; bus.cmd_rb = 2'd1; bus.cmd_rd = 2'd2; bus.cmd_count = 3'd0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.cmd_valid = (i != 1);
      bus.cmd_op = 3'b100; bus.cmd_ra = 2'd3; bus.cmd_rb = 2'd3; bus.cmd_rd = 2'd1; bus.cmd_count = 3'd7;
      check($sformatf("bp%0d_valid", i), bus.rsp_valid, 1);
      check($sformatf("bp%0d_ready", i), bus.cmd_ready, 0);
      check($sformatf("bp%0d_data", i), bus.rsp_data, 8'h10);
      check($sformatf("bp%0d_rd", i), bus.rsp_rd, 2);
      check($sformatf("bp%0d_zero", i), bus.rsp_zero, 0);
      check($sformatf("bp%0d_alu_a", i), bus.alu_a, 0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    check("bp_release_valid", bus.rsp_valid, 1);
    tick();
    bus.rsp_ready = 1'b0;
    check("bp_after_cmd_ready", bus.cmd_ready, 1);
    check("bp_after_rsp_valid", bus.rsp_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | bus.rsp_valid | ~bus.cmd_ready;
    end
    check("bp_no_ghost_cmd", seen, 0);
    read_reg(2'd2, 8'h10, "bp_r2");

    // Writeback and load to the same register on the same edge: writeback wins.
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'b000; bus.cmd_ra = 2'd0; bus.cmd_rb = 2'd1; bus.cmd_rd = 2'd2; bus.cmd_count = 3'd0;
    tick();
    bus.cmd_valid = 1'b0;
    bus.ld_en = 1'b1; bus.ld_addr = 2'd2; bus.ld_data = 8'hAA;
    tick();
    bus.ld_en = 1'b0;
    check("col_same_data", bus.rsp_data, 8'h10);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    read_reg(2'd2, 8'h10, "col_same_r2");

    // Writeback and load to different registers on the same edge: both land.
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.ld_en = 1'b1; bus.ld_addr = 2'd1; bus.ld_data = 8'hAA;
    tick();
    bus.ld_en = 1'b0;
    check("col_diff_data", bus.rsp_data, 8'h10);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    read_reg(2'd1, 8'hAA, "col_diff_r1");
    read_reg(2'd2, 8'h10, "col_diff_r2");

    // Load in the accept cycle: operands use the value from before the load.
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'b000; bus.cmd_ra = 2'd0; bus.cmd_rb = 2'd0; bus.cmd_rd = 2'd3; bus.cmd_count = 3'd0;
    bus.ld_en = 1'b1; bus.ld_addr = 2'd0; bus.ld_data = 8'h50;
    tick();
    bus.cmd_valid = 1'b0;
    bus.ld_en = 1'b0;
    tick();
    check("acc_old_data", bus.rsp_data, 8'h1E);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    read_reg(2'd0, 8'h50, "acc_old_r0");
    read_reg(2'd3, 8'h1E, "acc_old_r3");

    // Reset during the second EXEC cycle of a long command.
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'b000; bus.cmd_ra = 2'd0; bus.cmd_rb = 2'd1; bus.cmd_rd = 2'd2; bus.cmd_count = 3'd7;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    check("mid_exec_busy", bus.cmd_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);
    check("mid_rst_alu_a", bus.alu_a, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | bus.rsp_valid;
    end
    check("mid_rst_no_rsp", seen, 0);
    check("mid_rst_ready_after", bus.cmd_ready, 1);
    for (int r = 0; r < 4; r++) read_reg(r[1:0], 8'h00, $sformatf("mid_rst_r%0d", r));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
